// File: rtl/hpi_pkg.sv
// Shared constants and state encoding for the CY7C67200 HPI sequencer.
package hpi_pkg;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_STALL,
    S_FIN
  } state_e;

endpackage

// File: rtl/hpi_phase_timer.sv
// Loadable down-counter shared by the setup, strobe and hold phases.
module hpi_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/hpi_burst_ctrl.sv
// HPI access sequencer: single and auto-increment burst accesses
// driven from a command / write-stream / read-stream interface.
module hpi_burst_ctrl
  import hpi_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int MAX_BURST  = 8,
  parameter int LEN_W      = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_reg,
  input  logic [1:0]        cmd_port,
  input  logic [15:0]       cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic              hpi_cs_n,
  output logic              hpi_r_n,
  output logic              hpi_w_n,
  output logic [1:0]        hpi_addr,
  output logic [DATA_W-1:0] hpi_data_out,
  output logic              hpi_data_oe,
  input  logic [DATA_W-1:0] hpi_data_in
);

  localparam int MAX_SH = (SETUP_CYC > HOLD_CYC) ?
                          SETUP_CYC : HOLD_CYC;
  localparam int MAXC   = (STROBE_CYC > MAX_SH) ?
                          STROBE_CYC : MAX_SH;
  localparam int TW     = $clog2(MAXC) + 1;

  localparam logic [TW-1:0] SET_LD = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] STB_LD = TW'(STROBE_CYC - 1);
  localparam logic [TW-1:0] HLD_LD = TW'(HOLD_CYC - 1);

  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] MAXB = LEN_W'(MAX_BURST);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic              reg_q, reg_d;
  logic [1:0]        port_q, port_d;
  logic              aph_q, aph_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              rdv_q, rdv_d;
  logic              rlast_q, rlast_d;

  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_exp;
  logic              wr_acc;
  logic              rd_blk;
  logic [LEN_W-1:0]  len_c;
  state_e            next_acc;

  hpi_phase_timer #(.W(TW)) u_timer (
    .clk_i      (clk_clk),
    .rst_i      (reset_reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_exp)
  );

  // Address phase is always a write of cmd_addr
  assign wr_acc = aph_q | write_q;
  assign rd_blk = rdv_q & ~rd_ready;

  always_comb begin
    len_c = cmd_len;
    if (cmd_len == '0)       len_c = ONE;
    else if (cmd_len > MAXB) len_c = MAXB;
  end

  always_comb begin
    next_acc = S_SETUP;
    if (write_q)     next_acc = S_FETCH;
    else if (rd_blk) next_acc = S_STALL;
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    reg_d   = reg_q;
    port_d  = port_q;
    aph_d   = aph_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    start_d = start_q;
    rdat_d  = rdat_q;
    rdv_d   = rdv_q;
    rlast_d = rlast_q;

    if (rdv_q && rd_ready) rdv_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        start_d = 1'b0;
        if (cmd_valid) begin
          write_d = cmd_write;
          reg_d   = cmd_reg;
          port_d  = cmd_port;
          aph_d   = ~cmd_reg;
          cnt_d   = len_c;
          data_d  = DATA_W'(cmd_addr);
          if (!cmd_reg)       state_d = S_SETUP;
          else if (cmd_write) state_d = S_FETCH;
          else if (rd_blk)    state_d = S_STALL;
          else                state_d = S_SETUP;
        end
      end
      S_FETCH: begin
        if (wr_valid) begin
          data_d  = wr_data;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        start_d = 1'b1;
        if (tmr_exp) state_d = S_STROBE;
      end
      S_STROBE: begin
        if (tmr_exp) begin
          state_d = S_HOLD;
          if (!wr_acc) begin
            rdat_d  = hpi_data_in;
            rdv_d   = 1'b1;
            rlast_d = (cnt_q == ONE);
          end
        end
      end
      S_HOLD: begin
        if (tmr_exp) begin
          if (aph_q) begin
            aph_d   = 1'b0;
            state_d = next_acc;
          end else if (cnt_q == ONE) begin
            state_d = S_FIN;
          end else begin
            cnt_d   = cnt_q - ONE;
            state_d = next_acc;
          end
        end
      end
      S_STALL: begin
        if (!rd_blk) state_d = S_SETUP;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    unique case (state_d)
      S_SETUP:  tmr_val = SET_LD;
      S_STROBE: tmr_val = STB_LD;
      S_HOLD:   tmr_val = HLD_LD;
      default:  tmr_val = '0;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      reg_q   <= 1'b0;
      port_q  <= 2'd0;
      aph_q   <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      rdat_q  <= '0;
      rdv_q   <= 1'b0;
      rlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      reg_q   <= reg_d;
      port_q  <= port_d;
      aph_q   <= aph_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      start_q <= start_d;
      rdat_q  <= rdat_d;
      rdv_q   <= rdv_d;
      rlast_q <= rlast_d;
    end
  end

  logic phase;
  assign phase = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                 (state_q == S_HOLD);

  // Chip select spans the whole burst, including later write fetches
  assign hpi_cs_n = ~(phase || (state_q == S_STALL) ||
                      ((state_q == S_FETCH) && start_q));
  assign hpi_r_n  = ~((state_q == S_STROBE) && !wr_acc);
  assign hpi_w_n  = ~((state_q == S_STROBE) && wr_acc);

  always_comb begin
    hpi_addr = HPI_DATA;
    if (state_q != S_IDLE && state_q != S_FIN) begin
      if (aph_q)      hpi_addr = HPI_ADDR;
      else if (reg_q) hpi_addr = port_q;
    end
  end

  assign hpi_data_out = data_q;
  assign hpi_data_oe  = phase && wr_acc;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign wr_ready  = (state_q == S_FETCH) && wr_valid;
  assign rd_valid  = rdv_q;
  assign rd_data   = rdat_q;
  assign rd_last   = rlast_q;

endmodule

// File: tb/tb_hpi_burst_ctrl.sv
// Self-checking bench for hpi_burst_ctrl with an HPI bus-level reference model.
module tb_hpi_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_reg;
  logic [1:0]  cmd_port;
  logic [15:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [15:0] rd_data;
  logic        busy, done;
  logic        hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_oe;
  logic [1:0]  hpi_addr;
  logic [15:0] hpi_data_out, hpi_data_in;

  always #5 clk = ~clk;

  hpi_burst_ctrl dut (
    .clk_clk(clk), .reset_reset(reset_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_reg(cmd_reg),
    .cmd_port(cmd_port), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .busy(busy), .done(done),
    .hpi_cs_n(hpi_cs_n), .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n),
    .hpi_addr(hpi_addr), .hpi_data_out(hpi_data_out),
    .hpi_data_oe(hpi_data_oe), .hpi_data_in(hpi_data_in)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [18:0] bus_got[$], exp_bus[$];
  logic [16:0] rd_got[$], exp_rd[$];
  logic [15:0] rd_src[$], wq[$], fix_q[$];
  int cs_runs[$];
  int viol, oe_gap, done_cnt, done_rise, wr_cnt, rfall;
  int cyc = 0, acc_cyc = 0, last_lat = -1;
  int slen = 0, cs_len = 0;
  logic prev_r = 1'b1, prev_w = 1'b1, prev_rdv = 1'b0;
  int rdy_mode = 0, stall_left = 0;

  // Bus monitor and HPI slave: records every strobe as {write, port, data}
  always @(negedge clk) begin
    cyc++;
    if (reset_reset) begin
      prev_r = 1'b1; prev_w = 1'b1; prev_rdv = 1'b0;
      slen = 0; cs_len = 0;
    end else begin
      if (!hpi_r_n && !hpi_w_n) viol++;
      if ((!hpi_r_n || !hpi_w_n) && hpi_cs_n) viol++;
      if (!hpi_r_n && prev_r) begin
        hpi_data_in = (rd_src.size() != 0) ? rd_src.pop_front()
                                           : 16'($urandom);
        bus_got.push_back({1'b0, hpi_addr, hpi_data_in});
        rfall++;
      end
      if (!hpi_w_n && prev_w) begin
        bus_got.push_back({1'b1, hpi_addr, hpi_data_out});
        if (!hpi_data_oe) viol++;
      end
      if (!hpi_r_n || !hpi_w_n) slen++;
      else if (slen != 0) begin
        if (slen != 2) viol++;
        slen = 0;
      end
      if (!hpi_cs_n) cs_len++;
      else if (cs_len != 0) begin
        cs_runs.push_back(cs_len);
        cs_len = 0;
        if (done) done_rise++;
      end
      if (!hpi_cs_n && !hpi_data_oe) oe_gap++;
      if (done) done_cnt++;
      if (wr_ready) wr_cnt++;
      if (rd_valid && rd_ready) rd_got.push_back({rd_last, rd_data});
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (rd_valid && !prev_rdv && last_lat < 0) last_lat = cyc - acc_cyc;
      prev_r = hpi_r_n; prev_w = hpi_w_n; prev_rdv = rd_valid;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) rd_ready = 1'b1;
    else if (rdy_mode == 1) rd_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 3) rd_ready = 1'b0;
    else if (rd_valid && stall_left > 0) begin
      rd_ready = 1'b0;
      stall_left--;
    end else rd_ready = (stall_left == 0);
  end

  function automatic int eff_len(input int l);
    if (l == 0) return 1;
    if (l > 8) return 8;
    return l;
  endfunction

  task automatic clear_mon();
    bus_got.delete(); exp_bus.delete();
    rd_got.delete(); exp_rd.delete();
    rd_src.delete(); wq.delete(); cs_runs.delete();
    viol = 0; oe_gap = 0; done_cnt = 0; done_rise = 0;
    wr_cnt = 0; rfall = 0; last_lat = -1;
  endtask

  task automatic issue_cmd(input logic w, input logic r,
                           input logic [1:0] p, input logic [15:0] a,
                           input int l);
    int k;
    @(posedge clk); #1;
    cmd_write = w; cmd_reg = r; cmd_port = p;
    cmd_addr = a; cmd_len = 4'(l); cmd_valid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!cmd_ready && k < 50);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic writer(input int n, input int gap);
    int g, k;
    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) @(posedge clk);
      #1;
      wr_valid = 1'b1; wr_data = wq[i];
      k = 0;
      do begin @(negedge clk); k++; end while (!wr_ready && k < 300);
      @(posedge clk); #1;
      wr_valid = 1'b0;
    end
  endtask

  task automatic run_cmd(input logic w, input logic r,
                         input logic [1:0] p, input logic [15:0] a,
                         input int l, input int gap, input int mode,
                         input string nm);
    int n, k;
    logic [15:0] v;
    clear_mon();
    n = eff_len(l);
    if (!r) exp_bus.push_back({1'b1, 2'd2, a});
    for (int i = 0; i < n; i++) begin
      v = (fix_q.size() != 0) ? fix_q.pop_front() : 16'($urandom);
      exp_bus.push_back({w, r ? p : 2'd0, v});
      if (w) wq.push_back(v);
      else begin
        rd_src.push_back(v);
        exp_rd.push_back({(i == n - 1), v});
      end
    end
    rdy_mode = mode;
    fork
      issue_cmd(w, r, p, a, l);
      begin if (w) writer(n, gap); end
    join
    k = 0;
    while (done_cnt == 0 && k < 600) begin @(negedge clk); #1; k++; end
    n_chk++;
    if (done_cnt == 0) $display("FAIL %s done_timeout got 0 required 1", nm);
    else n_pass++;
    while (rd_got.size() < exp_rd.size() && k < 1200) begin
      @(negedge clk); #1; k++;
    end
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (done_cnt !== 1) $display("FAIL %s done_pulses got %0d required 1", nm, done_cnt);
    else n_pass++;
    n_chk++;
    if (bus_got.size() !== exp_bus.size())
      $display("FAIL %s bus_count got %0d required %0d", nm, bus_got.size(), exp_bus.size());
    else n_pass++;
    for (int i = 0; i < exp_bus.size(); i++) begin
      n_chk++;
      if (i >= bus_got.size())
        $display("FAIL %s bus[%0d] missing required %h", nm, i, exp_bus[i]);
      else if (bus_got[i] !== exp_bus[i])
        $display("FAIL %s bus[%0d] got %h required %h", nm, i, bus_got[i], exp_bus[i]);
      else n_pass++;
    end
    n_chk++;
    if (rd_got.size() !== exp_rd.size())
      $display("FAIL %s rd_count got %0d required %0d", nm, rd_got.size(), exp_rd.size());
    else n_pass++;
    for (int i = 0; i < exp_rd.size(); i++) begin
      n_chk++;
      if (i >= rd_got.size())
        $display("FAIL %s rd[%0d] missing required %h", nm, i, exp_rd[i]);
      else if (rd_got[i] !== exp_rd[i])
        $display("FAIL %s rd[%0d] got %h required %h", nm, i, rd_got[i], exp_rd[i]);
      else n_pass++;
    end
    n_chk++;
    if (viol !== 0) $display("FAIL %s bus_rules got %0d violations required 0", nm, viol);
    else n_pass++;
    if (w) begin
      n_chk++;
      if (wr_cnt !== n) $display("FAIL %s wr_ready_pulses got %0d required %0d", nm, wr_cnt, n);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_reg = 0; cmd_port = 0;
    cmd_addr = 0; cmd_len = 0; wr_valid = 0; wr_data = 0;
    rd_ready = 1'b1; hpi_data_in = 0;
    #1;
    n_chk++;
    if ({hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_oe, hpi_addr} !== 6'b111000)
      $display("FAIL reset_pins got %b required 111000",
               {hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_oe, hpi_addr});
    else n_pass++;
    n_chk++;
    if ({rd_valid, busy, done, wr_ready} !== 4'b0000)
      $display("FAIL reset_status got %b required 0000", {rd_valid, busy, done, wr_ready});
    else n_pass++;
    repeat (3) @(negedge clk);
    #1 reset_reset = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b required 1", cmd_ready);
    else n_pass++;
  endtask

  task automatic test_reg_write();
    fix_q.push_back(16'hBEEF);
    run_cmd(1'b1, 1'b1, 2'd1, 16'h0, 1, 0, 0, "reg_write");
    n_chk++;
    if (cs_runs.size() !== 1 || cs_runs[0] !== 4)
      $display("FAIL reg_write_cs_low runs %0d first %0d required 1 run of 4",
               cs_runs.size(), (cs_runs.size() != 0) ? cs_runs[0] : -1);
    else n_pass++;
    n_chk++;
    if (done_rise !== 1) $display("FAIL reg_write_done_at_cs_rise got %0d required 1", done_rise);
    else n_pass++;
    n_chk++;
    if (oe_gap !== 0) $display("FAIL reg_write_oe got %0d gaps required 0", oe_gap);
    else n_pass++;
  endtask

  task automatic test_mem_read();
    for (int i = 0; i < 4; i++) fix_q.push_back(16'(8'hA0 + i));
    run_cmd(1'b0, 1'b0, 2'd0, 16'h1000, 4, 0, 0, "mem_read");
    n_chk++;
    if (cs_runs.size() !== 1) $display("FAIL mem_read_cs_runs got %0d required 1", cs_runs.size());
    else n_pass++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) fix_q.push_back(16'(8'hA0 + i));
    stall_left = 10;
    run_cmd(1'b0, 1'b0, 2'd0, 16'h1000, 4, 0, 2, "stall");
    n_chk++;
    if (cs_runs.size() !== 1) $display("FAIL stall_cs_runs got %0d required 1", cs_runs.size());
    else n_pass++;
  endtask

  task automatic test_write_gap();
    run_cmd(1'b1, 1'b1, 2'd1, 16'h0, 3, 5, 0, "write_gap");
    n_chk++;
    if (cs_runs.size() !== 1) $display("FAIL write_gap_cs_runs got %0d required 1", cs_runs.size());
    else n_pass++;
  endtask

  task automatic test_latency();
    run_cmd(1'b0, 1'b1, 2'd1, 16'h0, 1, 0, 0, "lat_reg");
    n_chk++;
    if (last_lat !== 4) $display("FAIL lat_reg got %0d required 4", last_lat);
    else n_pass++;
    run_cmd(1'b0, 1'b0, 2'd0, 16'h0ABC, 1, 0, 0, "lat_mem");
    n_chk++;
    if (last_lat !== 8) $display("FAIL lat_mem got %0d required 8", last_lat);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k;
    clear_mon();
    rdy_mode = 3;
    issue_cmd(1'b0, 1'b1, 2'd3, 16'h0, 1);
    k = 0;
    while (done_cnt == 0 && k < 100) begin @(negedge clk); #1; k++; end
    n_chk++;
    if (rd_valid !== 1'b1) $display("FAIL rstA_word_held got %b required 1", rd_valid);
    else n_pass++;
    issue_cmd(1'b0, 1'b0, 2'd0, 16'h2000, 4);
    k = 0;
    while (hpi_w_n && k < 100) begin @(negedge clk); #1; k++; end
    reset_reset = 1'b1;
    #1;
    n_chk++;
    if ({hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_oe, busy, rd_valid} !== 6'b111000)
      $display("FAIL rstA_immediate got %b required 111000",
               {hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_oe, busy, rd_valid});
    else n_pass++;
    @(negedge clk); #1 reset_reset = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if ({cmd_ready, rd_valid} !== 2'b10)
      $display("FAIL rstA_after got %b required 10", {cmd_ready, rd_valid});
    else n_pass++;

    clear_mon();
    rdy_mode = 0;
    issue_cmd(1'b0, 1'b0, 2'd0, 16'h3000, 4);
    k = 0;
    while (!(rfall >= 2 && !hpi_r_n) && k < 200) begin @(negedge clk); #1; k++; end
    n_chk++;
    if (hpi_r_n !== 1'b0) $display("FAIL rstB_strobe_reached got %b required 0", hpi_r_n);
    else n_pass++;
    reset_reset = 1'b1;
    #1;
    n_chk++;
    if ({hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_oe} !== 4'b1110)
      $display("FAIL rstB_immediate got %b required 1110",
               {hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_oe});
    else n_pass++;
    @(negedge clk); #1 reset_reset = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if ({cmd_ready, rd_valid} !== 2'b10)
      $display("FAIL rstB_after got %b required 10", {cmd_ready, rd_valid});
    else n_pass++;
    run_cmd(1'b0, 1'b1, 2'd2, 16'h0, 2, 0, 0, "post_reset");
  endtask

  task automatic test_len_edges();
    int k;
    run_cmd(1'($urandom_range(0, 1)), 1'b1, 2'd1, 16'h0, 0, -1, 0, "len0");
    run_cmd(1'b0, 1'b0, 2'd0, 16'h4000, 15, -1, 1, "len15_rd");
    run_cmd(1'b1, 1'b0, 2'd0, 16'h4100, 15, -1, 0, "len15_wr");
    fork
      run_cmd(1'b0, 1'b1, 2'd1, 16'h0, 3, -1, 0, "busy_ign");
      begin
        k = 0;
        do begin @(negedge clk); #1; k++; end while (!busy && k < 50);
        cmd_write = 1'b1; cmd_reg = 1'b1; cmd_port = 2'd3;
        cmd_len = 4'd2; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0 || bus_got.size() !== 3)
      $display("FAIL busy_ignored busy %b accesses %0d required 0 and 3", busy, bus_got.size());
    else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++)
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 16'($urandom),
              int'($urandom_range(0, 15)), -1,
              int'($urandom_range(0, 1)), "random");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_reg_write();
    test_mem_read();
    test_stall();
    test_write_gap();
    test_latency();
    test_reset_mid();
    test_len_edges();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
